// File: rtl/reorder_buffer_mw.sv
// reorder_buffer_mw: in-order allocate, multi-channel out-of-order writeback,
// in-order single retire per cycle, with commit-time misprediction redirect.
// Handshake: an allocation is accepted on a rising edge where rdy is high,
// alloc_valid is high and alloc_ready (= !full, from registered count) is
// high; a request that is not accepted must be held by the producer.
module reorder_buffer_mw #(
   parameter int DEPTH    = 16,
   parameter int TAG_W    = 4,
   parameter int WB_PORTS = 3,
   parameter int XLEN     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      flush,
   input  logic                      alloc_valid,
   output logic                      alloc_ready,
   output logic [TAG_W-1:0]          alloc_tag,
   input  logic [4:0]                alloc_dest,
   input  logic [31:0]               alloc_pc,
   input  logic [1:0]                alloc_kind,
   input  logic                      alloc_done,
   input  logic [XLEN-1:0]           alloc_value,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
   input  logic [WB_PORTS*XLEN-1:0]  wb_value,
   input  logic [WB_PORTS-1:0]       wb_mispredict,
   input  logic [WB_PORTS*32-1:0]    wb_target,
   output logic                      commit_valid,
   output logic [TAG_W-1:0]          commit_tag,
   output logic [4:0]                commit_dest,
   output logic [XLEN-1:0]           commit_value,
   output logic [1:0]                commit_kind,
   output logic                      redirect_valid,
   output logic [31:0]               redirect_pc,
   output logic [TAG_W:0]            count,
   output logic                      empty,
   output logic                      full
);

   localparam logic [TAG_W:0] C_DEPTH = (TAG_W+1)'(DEPTH);

   // control state (reset)
   logic [DEPTH-1:0] r_busy;
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;
   logic             r_commit_valid;
   logic [TAG_W-1:0] r_commit_tag;
   logic [4:0]       r_commit_dest;
   logic [XLEN-1:0]  r_commit_value;
   logic [1:0]       r_commit_kind;
   logic             r_redirect_valid;
   logic [31:0]      r_redirect_pc;

   // per-entry payload (meaningful only while the busy bit is set)
   logic [DEPTH-1:0] r_done;
   logic [DEPTH-1:0] r_mispred;
   logic [4:0]       r_dest   [DEPTH];
   logic [1:0]       r_kind   [DEPTH];
   logic [XLEN-1:0]  r_value  [DEPTH];
   logic [31:0]      r_target [DEPTH];

   logic w_full;
   logic w_alloc;
   logic w_commit;
   logic w_clear;

   assign w_full   = (r_count == C_DEPTH);
   assign w_alloc  = alloc_valid && !w_full;
   // commit decision looks only at registered state, so a same-cycle
   // writeback to the head entry retires one cycle later
   assign w_commit = r_busy[r_head] && r_done[r_head];
   // a redirect retire self-flushes on the following enabled edge
   assign w_clear  = flush || r_redirect_valid;

   assign alloc_ready    = !w_full;
   assign alloc_tag      = r_tail;
   assign count          = r_count;
   assign empty          = (r_count == '0);
   assign full           = w_full;
   assign commit_valid   = r_commit_valid;
   assign commit_tag     = r_commit_tag;
   assign commit_dest    = r_commit_dest;
   assign commit_value   = r_commit_value;
   assign commit_kind    = r_commit_kind;
   assign redirect_valid = r_redirect_valid;
   assign redirect_pc    = r_redirect_pc;

   // pointers, occupancy, busy bits and the registered retire/redirect outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_busy           <= '0;
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_commit_valid   <= 1'b0;
         r_commit_tag     <= '0;
         r_commit_dest    <= '0;
         r_commit_value   <= '0;
         r_commit_kind    <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else if (rdy) begin
         if (w_clear) begin
            r_busy           <= '0;
            r_head           <= '0;
            r_tail           <= '0;
            r_count          <= '0;
            r_commit_valid   <= 1'b0;
            r_redirect_valid <= 1'b0;
         end else begin
            if (w_commit) begin
               r_busy[r_head]   <= 1'b0;
               r_head           <= r_head + TAG_W'(1);
               r_commit_valid   <= 1'b1;
               r_commit_tag     <= r_head;
               r_commit_dest    <= r_dest[r_head];
               r_commit_value   <= r_value[r_head];
               r_commit_kind    <= r_kind[r_head];
               // only branch (2) and jalr (3) can redirect
               r_redirect_valid <= r_mispred[r_head] && r_kind[r_head][1];
               if (r_mispred[r_head] && r_kind[r_head][1])
                  r_redirect_pc <= r_target[r_head];
            end else begin
               r_commit_valid   <= 1'b0;
               r_redirect_valid <= 1'b0;
            end
            // tail slot is never busy here when not full, so no clash with head
            if (w_alloc) begin
               r_busy[r_tail] <= 1'b1;
               r_tail         <= r_tail + TAG_W'(1);
            end
            if (w_alloc && !w_commit)
               r_count <= r_count + (TAG_W+1)'(1);
            else if (!w_alloc && w_commit)
               r_count <= r_count - (TAG_W+1)'(1);
         end
      end
   end

   // entry payload: writebacks in ascending channel order (highest wins), then allocation
   always_ff @(posedge clk) begin
      if (rdy) begin
         for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_valid[p] && r_busy[wb_tag[p*TAG_W +: TAG_W]]) begin
               r_done[wb_tag[p*TAG_W +: TAG_W]]    <= 1'b1;
               r_value[wb_tag[p*TAG_W +: TAG_W]]   <= wb_value[p*XLEN +: XLEN];
               r_mispred[wb_tag[p*TAG_W +: TAG_W]] <= wb_mispredict[p];
               r_target[wb_tag[p*TAG_W +: TAG_W]]  <= wb_target[p*32 +: 32];
            end
         end
         if (w_alloc) begin
            r_done[r_tail]    <= alloc_done;
            r_mispred[r_tail] <= 1'b0;
            r_dest[r_tail]    <= alloc_dest;
            r_kind[r_tail]    <= alloc_kind;
            r_value[r_tail]   <= alloc_done ? alloc_value : '0;
            r_target[r_tail]  <= alloc_pc + 32'd4;
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Directed bench for reorder_buffer_mw with a tag-order scoreboard and a
// small entry model that supplies the expected retire fields.
module tb_reorder_buffer_mw;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  localparam int WBP   = 3;
  localparam int XLEN  = 32;
  localparam int EW    = 76;

  logic                  clk;
  logic                  rst;
  logic                  rdy;
  logic                  flush;
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [TAG_W-1:0]      alloc_tag;
  logic [4:0]            alloc_dest;
  logic [31:0]           alloc_pc;
  logic [1:0]            alloc_kind;
  logic                  alloc_done;
  logic [XLEN-1:0]       alloc_value;
  logic [WBP-1:0]        wb_valid;
  logic [WBP*TAG_W-1:0]  wb_tag;
  logic [WBP*XLEN-1:0]   wb_value;
  logic [WBP-1:0]        wb_mispredict;
  logic [WBP*32-1:0]     wb_target;
  logic                  commit_valid;
  logic [TAG_W-1:0]      commit_tag;
  logic [4:0]            commit_dest;
  logic [XLEN-1:0]       commit_value;
  logic [1:0]            commit_kind;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic [TAG_W:0]        count;
  logic                  empty;
  logic                  full;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: tags in program order, entry model indexed by tag
  logic [TAG_W-1:0] exp_q[$];
  logic [DEPTH-1:0] m_busy;
  logic [DEPTH-1:0] m_mis;
  logic [4:0]       m_dest [DEPTH];
  logic [1:0]       m_kind [DEPTH];
  logic [31:0]      m_val  [DEPTH];
  logic [31:0]      m_tgt  [DEPTH];
  logic [TAG_W-1:0] m_tail;
  int               m_cnt;
  logic             en_q;

  reorder_buffer_mw #(.DEPTH(DEPTH), .TAG_W(TAG_W), .WB_PORTS(WBP), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_dest(alloc_dest), .alloc_pc(alloc_pc), .alloc_kind(alloc_kind),
    .alloc_done(alloc_done), .alloc_value(alloc_value),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_mispredict(wb_mispredict), .wb_target(wb_target),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_dest(commit_dest),
    .commit_value(commit_value), .commit_kind(commit_kind),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .empty(empty), .full(full)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) en_q = rdy;

  task automatic chk(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, expv);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_busy = '0;
    m_tail = '0;
    m_cnt  = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // driver: one allocation request held for one edge
  task automatic do_alloc(input logic [4:0] d, input logic [31:0] pc, input logic [1:0] k,
                          input logic dn, input logic [31:0] v);
    logic acc;
    acc = (m_cnt < DEPTH);
    alloc_valid = 1'b1;
    alloc_dest  = d;
    alloc_pc    = pc;
    alloc_kind  = k;
    alloc_done  = dn;
    alloc_value = v;
    chk("alloc_ready", EW'(alloc_ready), EW'(acc));
    chk("alloc_tag", EW'(alloc_tag), EW'(m_tail));
    if (acc) begin
      exp_q.push_back(m_tail);
      m_busy[m_tail] = 1'b1;
      m_mis[m_tail]  = 1'b0;
      m_dest[m_tail] = d;
      m_kind[m_tail] = k;
      m_val[m_tail]  = dn ? v : 32'd0;
      m_tgt[m_tail]  = pc + 32'd4;
      m_tail         = m_tail + 4'd1;
      m_cnt++;
    end
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic set_wb(input int ch, input logic [TAG_W-1:0] t, input logic [31:0] v,
                        input logic mis, input logic [31:0] tgt);
    wb_valid[ch]            = 1'b1;
    wb_tag[ch*TAG_W +: TAG_W] = t;
    wb_value[ch*XLEN +: XLEN] = v;
    wb_mispredict[ch]       = mis;
    wb_target[ch*32 +: 32]  = tgt;
  endtask

  // apply the staged writebacks to the model in channel order, then clock them in
  task automatic wb_go();
    logic [TAG_W-1:0] t;
    for (int p = 0; p < WBP; p++) begin
      t = wb_tag[p*TAG_W +: TAG_W];
      if (wb_valid[p] && m_busy[t]) begin
        m_val[t] = wb_value[p*XLEN +: XLEN];
        m_mis[t] = wb_mispredict[p];
        m_tgt[t] = wb_target[p*32 +: 32];
      end
    end
    step();
    wb_valid = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    chk("drain", EW'(exp_q.size() == 0), EW'(1));
  endtask

  // scoreboard: every enabled-edge retire pops the next program-order tag
  always @(negedge clk) begin
    logic [TAG_W-1:0] t;
    logic             redir;
    logic [EW-1:0]    expv;
    logic [EW-1:0]    obs;
    if (rst && en_q) begin
      chk("redirect_without_commit", EW'(redirect_valid && !commit_valid), EW'(0));
      if (commit_valid) begin
        chk("commit_expected", EW'(exp_q.size() != 0), EW'(1));
        if (exp_q.size() != 0) begin
          t     = exp_q.pop_front();
          redir = m_mis[t] && m_kind[t][1];
          expv  = {redir, redir ? m_tgt[t] : 32'd0, m_kind[t], m_val[t], m_dest[t], t};
          obs   = {redirect_valid, redirect_valid ? redirect_pc : 32'd0, commit_kind,
                   commit_value, commit_dest, commit_tag};
          chk("commit", obs, expv);
          m_busy[t] = 1'b0;
          m_cnt--;
          if (redir) model_clear();
        end
      end
    end
  end

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    alloc_valid = 1'b0; alloc_dest = '0; alloc_pc = '0; alloc_kind = '0;
    alloc_done = 1'b0; alloc_value = '0;
    wb_valid = '0; wb_tag = '0; wb_value = '0; wb_mispredict = '0; wb_target = '0;
    en_q = 1'b0;
    m_mis = '0;
    model_clear();
    step();
    step();
    // reset state
    chk("rst_alloc_ready", EW'(alloc_ready), EW'(1));
    chk("rst_count", EW'(count), EW'(0));
    chk("rst_empty", EW'(empty), EW'(1));
    chk("rst_full", EW'(full), EW'(0));
    chk("rst_commit", EW'({commit_valid, redirect_valid, commit_tag, commit_dest, commit_kind}), EW'(0));
    chk("rst_commit_value", EW'(commit_value), EW'(0));
    chk("rst_redirect_pc", EW'(redirect_pc), EW'(0));
    rst = 1'b1;
    step();

    // three complete-at-allocation entries retire back to back
    do_alloc(5'd1, 32'h0, 2'd0, 1'b1, 32'h11);
    do_alloc(5'd2, 32'h4, 2'd0, 1'b1, 32'h22);
    do_alloc(5'd3, 32'h8, 2'd0, 1'b1, 32'h33);
    drain(10);
    chk("t1_count", EW'(count), EW'(0));
    chk("t1_empty", EW'(empty), EW'(1));

    // fill, drop the 17th, retire tag 0, wrap the tail
    do_flush();
    for (int i = 0; i < DEPTH; i++)
      do_alloc(5'($urandom_range(1, 31)), 32'h1000 + 32'(i*4), 2'd0, 1'b0, 32'h0);
    chk("fill_full", EW'(full), EW'(1));
    chk("fill_count", EW'(count), EW'(DEPTH));
    do_alloc(5'd9, 32'h2000, 2'd0, 1'b1, 32'hDEAD);
    chk("drop_count", EW'(count), EW'(DEPTH));
    set_wb(0, 4'd0, 32'hAB, 1'b0, 32'h0);
    wb_go();
    step();
    chk("wrap_count", EW'(count), EW'(DEPTH - 1));
    chk("wrap_full", EW'(full), EW'(0));
    do_alloc(5'd4, 32'h3000, 2'd0, 1'b0, 32'h0);
    chk("wrap_refull", EW'(full), EW'(1));

    // out-of-order writeback on all channels in one cycle
    do_flush();
    do_alloc(5'd5, 32'h100, 2'd0, 1'b0, 32'h0);
    do_alloc(5'd6, 32'h104, 2'd1, 1'b0, 32'h0);
    do_alloc(5'd7, 32'h108, 2'd0, 1'b0, 32'h0);
    set_wb(0, 4'd2, 32'h202, 1'b0, 32'h0);
    set_wb(1, 4'd1, 32'h101, 1'b0, 32'h0);
    set_wb(2, 4'd0, 32'h100, 1'b0, 32'h0);
    wb_go();
    step();
    chk("ooo_count0", EW'(count), EW'(2));
    step();
    chk("ooo_count1", EW'(count), EW'(1));
    step();
    chk("ooo_count2", EW'(count), EW'(0));

    // same tag on two channels: highest channel wins; mispredict on a normal op is no redirect
    do_alloc(5'd8, 32'h10C, 2'd0, 1'b0, 32'h0);
    set_wb(0, 4'd3, 32'h5, 1'b0, 32'h0);
    set_wb(2, 4'd3, 32'h9, 1'b1, 32'h500);
    wb_go();
    drain(5);

    // branch mispredict at tag 1 with younger completed entries behind it
    do_flush();
    do_alloc(5'd1, 32'h30, 2'd0, 1'b0, 32'h0);
    do_alloc(5'd0, 32'h40, 2'd2, 1'b0, 32'h0);
    do_alloc(5'd2, 32'h44, 2'd0, 1'b1, 32'hC2);
    do_alloc(5'd3, 32'h48, 2'd0, 1'b1, 32'hC3);
    do_alloc(5'd4, 32'h4C, 2'd0, 1'b1, 32'hC4);
    set_wb(0, 4'd0, 32'h55, 1'b0, 32'h0);
    set_wb(1, 4'd1, 32'h0, 1'b1, 32'h100);
    wb_go();
    step();
    step();
    chk("br_redirect_valid", EW'(redirect_valid), EW'(1));
    chk("br_redirect_pc", EW'(redirect_pc), EW'(32'h100));
    step();
    chk("br_flush_count", EW'(count), EW'(0));
    chk("br_flush_commit", EW'({commit_valid, redirect_valid}), EW'(0));
    chk("br_flush_empty", EW'(empty), EW'(1));
    step();
    step();
    step();

    // external flush beats a committable head
    do_alloc(5'd10, 32'h60, 2'd0, 1'b1, 32'h66);
    do_flush();
    chk("flush_commit", EW'(commit_valid), EW'(0));
    chk("flush_count", EW'(count), EW'(0));

    // rdy low stalls a pending commit
    do_alloc(5'd11, 32'h70, 2'd0, 1'b1, 32'h77);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_no_commit", EW'(commit_valid), EW'(0));
      chk("stall_count", EW'(count), EW'(1));
    end
    rdy = 1'b1;
    step();
    chk("stall_release", EW'(commit_valid), EW'(1));

    // rdy low holds an issued pulse
    do_alloc(5'd12, 32'h74, 2'd3, 1'b1, 32'h88);
    step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pulse", EW'({commit_valid, commit_tag}), EW'({1'b1, 4'd1}));
      chk("hold_value", EW'(commit_value), EW'(32'h88));
    end
    rdy = 1'b1;
    step();
    chk("hold_release", EW'(commit_valid), EW'(0));

    // asynchronous reset mid-cycle with rdy low
    do_alloc(5'd13, 32'h80, 2'd0, 1'b0, 32'h0);
    chk("pre_reset_count", EW'(count), EW'(1));
    rdy = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", EW'(count), EW'(0));
    chk("async_rst_ready", EW'(alloc_ready), EW'(1));
    chk("async_rst_tag", EW'(alloc_tag), EW'(0));
    step();
    rst = 1'b1;
    rdy = 1'b1;
    model_clear();
    step();
    chk("end_queue", EW'(exp_q.size()), EW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
